regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the MIPS-based processor datapath, replacing the fixed 32x32 single-write file. It provides three asynchronous read ports and two synchronous write ports: port 0 for ALU writeback, port 1 for load return. It also has a per-register pending-write scoreboard for load-use stall detection, optional write-to-read bypass, and a registered write-conflict flag. Every register, including register 0, is cleared by an explicit reset rather than a first-clock initialisation pulse.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never becomes busy
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- claim  in  1  mark claim_addr as pending (load issued)
- claim_addr  in  ADDR_W  register to mark pending
- raddr1, raddr2, raddr3  in  ADDR_W each  read addresses
- rdata1, rdata2, rdata3  out  DATA_W each  read data (combinational)
- rbusy1, rbusy2, rbusy3  out  1 each  pending flag for the matching read address (combinational)
- busy_vec  out  2**ADDR_W  full scoreboard, bit i = register i pending
- wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same address in the previous cycle
- dbg_addr  in  ADDR_W  simulation observation address
- dbg_data  out  DATA_W  raw stored contents at dbg_addr (never bypassed)

## Operation
- Reset (rst=1, at any time, independent of clk): all registers = 0, busy_vec = 0, wr_conflict = 0. No writes or claims take effect while rst=1.
- Write:
  - On a rising edge with weN=1, regs[waddrN] <= wdataN.
  - If both ports are enabled with the same address, port 0 is stored, port 1 data is dropped, and wr_conflict = 1 for the next cycle.
- Register 0 when ZERO_REG=1:
  - Writes to address 0 are discarded and do not set wr_conflict.
  - Reads of address 0 return 0.
  - Claims of address 0 are ignored.
- Read, BYPASS=0: rdataK = stored regs[raddrK].
- Read, BYPASS=1: rdataK is selected by priority:
  - wdata0 if we0 and waddr0 == raddrK;
  - else wdata1 if we1 and waddr1 == raddrK;
  - else regs[raddrK].
  - ZERO_REG overrides the bypass.
- Scoreboard, evaluated per edge:
  - busy[a] is set if claim and claim_addr == a.
  - busy[a] is otherwise cleared if (we0 and waddr0 == a) or (we1 and waddr1 == a).
  - Claim and write to the same address in one cycle leave the bit set (the new load is outstanding).
  - Claiming an already busy register keeps it busy.
- rbusyK = busy[raddrK], with two overrides:
  - When BYPASS=1, rbusyK is forced 0 if a write to raddrK is present this cycle (the data is being forwarded).
  - rbusyK is always 0 for address 0 when ZERO_REG=1.
- Reads are combinational, with no read enable. Multiple read ports may share an address.

## Timing
- Write latency: 1 edge. When BYPASS=0 the stored value is visible on reads the cycle after we. When BYPASS=1 it is visible in the same cycle.
- Claim latency: 1 edge. busy_vec and rbusy reflect the claim the cycle after claim=1.
- wr_conflict is asserted in the cycle after the colliding edge and lasts exactly one cycle unless the collision repeats.
- Reset assertion clears outputs immediately without waiting for clk. After deassertion, the first rising edge performs normal writes and claims.
- Reset asserted mid-operation:
  - pending busy bits are lost;
  - in-flight writes on the asserting cycle are not stored.

## Test plan
- Reset then read: assert rst mid-run after writing 0xDEADBEEF to r7, then release. rdata1 with raddr1=7 must read 0x00000000, busy_vec = 0, wr_conflict = 0, with no clock edge needed for the clear.
- Write and bypass: we0=1, waddr0=5, wdata0=0x12345678, raddr2=5.
  - With BYPASS=1, rdata2 = 0x12345678 in the same cycle.
  - With BYPASS=0, rdata2 shows the old value, then 0x12345678 after the edge.
  - dbg_data at address 5 shows the old value, then the new one, in both modes.
- Register 0: we1=1, waddr1=0, wdata1=0xFFFFFFFF, plus claim of address 0. Reads of address 0 = 0, busy_vec[0] = 0, dbg_data at address 0 = 0.
- Collision: we0 and we1 both target r3, wdata0=0xAAAA0000, wdata1=0x5555FFFF. r3 = 0xAAAA0000 afterwards, wr_conflict pulses high for exactly one cycle. The bypassed read of r3 in the collision cycle returns 0xAAAA0000.
- Scoreboard:
  - Claim r9: rbusy with raddr=9 goes 1 the next cycle.
  - A later we1 to r9 makes rbusy 0 in that cycle when BYPASS=1, and busy_vec[9]=0 after the edge.
  - Simultaneous claim and write of r9 leaves busy_vec[9]=1.
- Parameter sweep: DATA_W=16, ADDR_W=3, repeating the write/read of all 8 registers with distinct patterns. No aliasing between addresses; busy_vec width = 8.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: three async read ports, two write ports (ALU, load),
// per-register pending-load scoreboard, optional write-to-read bypass.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic                  claim,
  input  logic [ADDR_W-1:0]     claim_addr,
  input  logic [ADDR_W-1:0]     raddr1,
  input  logic [ADDR_W-1:0]     raddr2,
  input  logic [ADDR_W-1:0]     raddr3,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2,
  output logic [DATA_W-1:0]     rdata3,
  output logic                  rbusy1,
  output logic                  rbusy2,
  output logic                  rbusy3,
  output logic [2**ADDR_W-1:0]  busy_vec,
  output logic                  wr_conflict,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok0;
  logic              wr_ok1;
  logic              collide;

  // Writes to a hardwired-zero register are discarded before they can collide.
  always_comb begin
    wr_ok0  = we0 && !(ZERO_REG && (waddr0 == '0));
    wr_ok1  = we1 && !(ZERO_REG && (waddr1 == '0));
    collide = wr_ok0 && wr_ok1 && (waddr0 == waddr1);
  end

  // A claim wins over a same-cycle write: the new load is still outstanding.
  always_comb begin
    busy_nxt = busy;
    for (int a = 0; a < DEPTH; a++) begin
      if (claim && (claim_addr == ADDR_W'(a)) && !(ZERO_REG && (a == 0)))
        busy_nxt[a] = 1'b1;
      else if ((we0 && (waddr0 == ADDR_W'(a))) || (we1 && (waddr1 == ADDR_W'(a))))
        busy_nxt[a] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (wr_ok0) regs[waddr0] <= wdata0;
      if (wr_ok1 && !collide) regs[waddr1] <= wdata1;
      busy        <= busy_nxt;
      wr_conflict <= collide;
    end
  end

  logic [ADDR_W-1:0] ra [3];
  logic [DATA_W-1:0] rd [3];
  logic              rb [3];

  assign ra[0] = raddr1;
  assign ra[1] = raddr2;
  assign ra[2] = raddr3;

  for (genvar k = 0; k < 3; k++) begin : g_rd
    logic fwd0;
    logic fwd1;
    logic is_zero;

    always_comb begin
      fwd0    = we0 && (waddr0 == ra[k]);
      fwd1    = we1 && (waddr1 == ra[k]);
      is_zero = ZERO_REG && (ra[k] == '0);
      rd[k]   = regs[ra[k]];
      if (BYPASS && fwd0)      rd[k] = wdata0;
      else if (BYPASS && fwd1) rd[k] = wdata1;
      if (is_zero) rd[k] = '0;
      rb[k] = busy[ra[k]] && !(BYPASS && (fwd0 || fwd1)) && !is_zero;
    end
  end

  assign rdata1   = rd[0];
  assign rdata2   = rd[1];
  assign rdata3   = rd[2];
  assign rbusy1   = rb[0];
  assign rbusy2   = rb[1];
  assign rbusy3   = rb[2];
  assign busy_vec = busy;
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and non-bypass 32x32 instances share
// stimulus; a 16-bit, 8-entry instance without a zero register covers the sweep.
module tb_regfile_mp;

  logic clk;
  logic rst;
  logic we0, we1, cl;
  logic [4:0] wa0, wa1, ca, ra1, ra2, ra3, da;
  logic [31:0] wd0, wd1;

  logic [31:0] a_rd1, a_rd2, a_rd3, a_bv, a_dbg;
  logic        a_rb1, a_rb2, a_rb3, a_conf;
  logic [31:0] b_rd1, b_rd2, b_rd3, b_bv, b_dbg;
  logic        b_rb1, b_rb2, b_rb3, b_conf;

  logic        c_we0, c_we1, c_cl;
  logic [2:0]  c_wa0, c_wa1, c_ca, c_ra1, c_ra2, c_ra3, c_da;
  logic [15:0] c_wd0, c_wd1, c_rd1, c_rd2, c_rd3, c_dbg;
  logic        c_rb1, c_rb2, c_rb3, c_conf;
  logic [7:0]  c_bv;

  int n_chk = 0;
  int n_fail = 0;

  regfile_mp #(.BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(wa0), .wdata0(wd0),
    .we1(we1), .waddr1(wa1), .wdata1(wd1), .claim(cl), .claim_addr(ca),
    .raddr1(ra1), .raddr2(ra2), .raddr3(ra3),
    .rdata1(a_rd1), .rdata2(a_rd2), .rdata3(a_rd3),
    .rbusy1(a_rb1), .rbusy2(a_rb2), .rbusy3(a_rb3),
    .busy_vec(a_bv), .wr_conflict(a_conf), .dbg_addr(da), .dbg_data(a_dbg));

  regfile_mp #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(wa0), .wdata0(wd0),
    .we1(we1), .waddr1(wa1), .wdata1(wd1), .claim(cl), .claim_addr(ca),
    .raddr1(ra1), .raddr2(ra2), .raddr3(ra3),
    .rdata1(b_rd1), .rdata2(b_rd2), .rdata3(b_rd3),
    .rbusy1(b_rb1), .rbusy2(b_rb2), .rbusy3(b_rb3),
    .busy_vec(b_bv), .wr_conflict(b_conf), .dbg_addr(da), .dbg_data(b_dbg));

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_c (
    .clk(clk), .rst(rst), .we0(c_we0), .waddr0(c_wa0), .wdata0(c_wd0),
    .we1(c_we1), .waddr1(c_wa1), .wdata1(c_wd1), .claim(c_cl), .claim_addr(c_ca),
    .raddr1(c_ra1), .raddr2(c_ra2), .raddr3(c_ra3),
    .rdata1(c_rd1), .rdata2(c_rd2), .rdata3(c_rd3),
    .rbusy1(c_rb1), .rbusy2(c_rb2), .rbusy3(c_rb3),
    .busy_vec(c_bv), .wr_conflict(c_conf), .dbg_addr(c_da), .dbg_data(c_dbg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic        cl;  logic [4:0] ca;
    logic [4:0]  ra1; logic [4:0] ra2; logic [4:0] ra3; logic [4:0] da;
    logic [31:0] e1;  logic [31:0] e2; logic [31:0] e3;
    logic [2:0]  erb; logic [31:0] ebv; logic [31:0] edbg; logic econf;
    logic [31:0] enb2; logic enbb;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    we0 = 1'b0; wa0 = '0; wd0 = '0; we1 = 1'b0; wa1 = '0; wd1 = '0;
    cl = 1'b0; ca = '0;
  endtask

  task automatic idle_c();
    c_we0 = 1'b0; c_wa0 = '0; c_wd0 = '0; c_we1 = 1'b0; c_wa1 = '0; c_wd1 = '0;
    c_cl = 1'b0; c_ca = '0;
  endtask

  initial begin
    // we0 wa0 wd0 | we1 wa1 wd1 | cl ca | ra1 ra2 ra3 da | e1 e2 e3 | rbusy{3,2,1} busy_vec dbg conf | nobypass rdata2, rbusy1
    vt[0]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd7,5'd5,5'd0,5'd5, 32'h0,32'h0,32'h0,                3'b000,32'h0,  32'h0,        1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b1,5'd5,32'h12345678, 1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd7,5'd5,5'd0,5'd5, 32'h0,32'h12345678,32'h0,         3'b000,32'h0,  32'h0,        1'b0, 32'h0,        1'b0};
    vt[2]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd7,5'd5,5'd0,5'd5, 32'h0,32'h12345678,32'h0,         3'b000,32'h0,  32'h12345678, 1'b0, 32'h12345678, 1'b0};
    vt[3]  = '{1'b0,5'd0,32'h0,        1'b1,5'd0,32'hFFFFFFFF, 1'b1,5'd0, 5'd0,5'd0,5'd0,5'd0, 32'h0,32'h0,32'h0,                3'b000,32'h0,  32'h0,        1'b0, 32'h0,        1'b0};
    vt[4]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd0,5'd0,5'd0,5'd0, 32'h0,32'h0,32'h0,                3'b000,32'h0,  32'h0,        1'b0, 32'h0,        1'b0};
    vt[5]  = '{1'b1,5'd3,32'hAAAA0000, 1'b1,5'd3,32'h5555FFFF, 1'b0,5'd0, 5'd3,5'd3,5'd5,5'd3, 32'hAAAA0000,32'hAAAA0000,32'h12345678, 3'b000,32'h0, 32'h0,   1'b0, 32'h0,        1'b0};
    vt[6]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd3,5'd3,5'd3,5'd3, 32'hAAAA0000,32'hAAAA0000,32'hAAAA0000, 3'b000,32'h0, 32'hAAAA0000, 1'b1, 32'hAAAA0000, 1'b0};
    vt[7]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd3,5'd3,5'd3,5'd3, 32'hAAAA0000,32'hAAAA0000,32'hAAAA0000, 3'b000,32'h0, 32'hAAAA0000, 1'b0, 32'hAAAA0000, 1'b0};
    vt[8]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd9, 5'd9,5'd9,5'd9,5'd9, 32'h0,32'h0,32'h0,                3'b000,32'h0,  32'h0,        1'b0, 32'h0,        1'b0};
    vt[9]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9,5'd9,5'd9,5'd9, 32'h0,32'h0,32'h0,                3'b111,32'h200,32'h0,        1'b0, 32'h0,        1'b1};
    vt[10] = '{1'b0,5'd0,32'h0,        1'b1,5'd9,32'hCAFEF00D, 1'b0,5'd0, 5'd9,5'd9,5'd3,5'd9, 32'hCAFEF00D,32'hCAFEF00D,32'hAAAA0000, 3'b000,32'h200, 32'h0, 1'b0, 32'h0,        1'b1};
    vt[11] = '{1'b1,5'd9,32'h11112222, 1'b0,5'd0,32'h0,        1'b1,5'd9, 5'd9,5'd9,5'd9,5'd9, 32'h11112222,32'h11112222,32'h11112222, 3'b000,32'h0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
    vt[12] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9,5'd9,5'd9,5'd9, 32'h11112222,32'h11112222,32'h11112222, 3'b111,32'h200, 32'h11112222, 1'b0, 32'h11112222, 1'b1};
    vt[13] = '{1'b1,5'd4,32'h44444444, 1'b1,5'd6,32'h66666666, 1'b0,5'd0, 5'd4,5'd6,5'd9,5'd4, 32'h44444444,32'h66666666,32'h11112222, 3'b100,32'h200, 32'h0, 1'b0, 32'h0,        1'b0};
    vt[14] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd4,5'd6,5'd9,5'd6, 32'h44444444,32'h66666666,32'h11112222, 3'b100,32'h200, 32'h66666666, 1'b0, 32'h66666666, 1'b0};
    vt[15] = '{1'b1,5'd0,32'h1,        1'b1,5'd0,32'h2,        1'b0,5'd0, 5'd0,5'd0,5'd0,5'd0, 32'h0,32'h0,32'h0,                3'b000,32'h200,32'h0,        1'b0, 32'h0,        1'b0};
    vt[16] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd0,5'd0,5'd0,5'd0, 32'h0,32'h0,32'h0,                3'b000,32'h200,32'h0,        1'b0, 32'h0,        1'b0};

    rst = 1'b1;
    idle_a(); idle_c();
    ra1 = '0; ra2 = '0; ra3 = '0; da = 5'd7;
    c_ra1 = '0; c_ra2 = '0; c_ra3 = '0; c_da = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset rdata1", a_rd1, 32'h0);
    chk("reset busy_vec", a_bv, 32'h0);
    chk("reset wr_conflict", {31'b0, a_conf}, 32'h0);
    chk("reset dbg r7", a_dbg, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      we0 = vt[i].we0; wa0 = vt[i].wa0; wd0 = vt[i].wd0;
      we1 = vt[i].we1; wa1 = vt[i].wa1; wd1 = vt[i].wd1;
      cl = vt[i].cl; ca = vt[i].ca;
      ra1 = vt[i].ra1; ra2 = vt[i].ra2; ra3 = vt[i].ra3; da = vt[i].da;
      #1;
      chk($sformatf("v%0d rdata1", i), a_rd1, vt[i].e1);
      chk($sformatf("v%0d rdata2", i), a_rd2, vt[i].e2);
      chk($sformatf("v%0d rdata3", i), a_rd3, vt[i].e3);
      chk($sformatf("v%0d rbusy", i), {29'b0, a_rb3, a_rb2, a_rb1}, {29'b0, vt[i].erb});
      chk($sformatf("v%0d busy_vec", i), a_bv, vt[i].ebv);
      chk($sformatf("v%0d dbg_data", i), a_dbg, vt[i].edbg);
      chk($sformatf("v%0d wr_conflict", i), {31'b0, a_conf}, {31'b0, vt[i].econf});
      chk($sformatf("v%0d nobyp rdata2", i), b_rd2, vt[i].enb2);
      chk($sformatf("v%0d nobyp rbusy1", i), {31'b0, b_rb1}, {31'b0, vt[i].enbb});
      chk($sformatf("v%0d nobyp dbg", i), b_dbg, vt[i].edbg);
    end

    // Mid-run reset: r7 holds data, r2 busy, conflict pending; clear must not wait for clk.
    @(negedge clk);
    idle_a();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hDEADBEEF;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0BADF00D;
    cl = 1'b1; ca = 5'd2;
    @(negedge clk);
    idle_a();
    ra1 = 5'd7; ra2 = 5'd2; ra3 = 5'd0; da = 5'd7;
    #1;
    chk("pre-rst rdata1 r7", a_rd1, 32'hDEADBEEF);
    chk("pre-rst wr_conflict", {31'b0, a_conf}, 32'h1);
    chk("pre-rst busy_vec", a_bv, 32'h0000_0204);
    chk("pre-rst rbusy2 r2", {31'b0, a_rb2}, 32'h1);
    #1;
    rst = 1'b1;
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h88888888;
    #1;
    chk("rst rdata1 r7", a_rd1, 32'h0);
    chk("rst nobyp rdata1 r7", b_rd1, 32'h0);
    chk("rst busy_vec", a_bv, 32'h0);
    chk("rst wr_conflict", {31'b0, a_conf}, 32'h0);
    chk("rst dbg r7", a_dbg, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h88888888;
    da = 5'd8;
    #1;
    chk("rst write dropped r8", a_dbg, 32'h0);
    @(negedge clk);
    idle_a();
    #1;
    chk("post-rst write r8", a_dbg, 32'h88888888);
    chk("post-rst rdata1 r7", a_rd1, 32'h0);

    // 16-bit x 8 sweep: alternate write ports, distinct patterns per register.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_c();
      if (i % 2 == 0) begin
        c_we0 = 1'b1; c_wa0 = 3'(i); c_wd0 = 16'h1111 * 16'(i + 1);
      end else begin
        c_we1 = 1'b1; c_wa1 = 3'(i); c_wd1 = 16'h1111 * 16'(i + 1);
      end
    end
    @(negedge clk);
    idle_c();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c_ra1 = 3'(i); c_ra2 = 3'(7 - i); c_ra3 = 3'(i); c_da = 3'(i);
      #1;
      chk($sformatf("sweep rdata1 r%0d", i), {16'b0, c_rd1}, {16'b0, 16'h1111 * 16'(i + 1)});
      chk($sformatf("sweep rdata2 r%0d", 7 - i), {16'b0, c_rd2}, {16'b0, 16'h1111 * 16'(8 - i)});
      chk($sformatf("sweep dbg r%0d", i), {16'b0, c_dbg}, {16'b0, 16'h1111 * 16'(i + 1)});
    end
    for (int i = 0; i < 8; i += 2) begin
      @(negedge clk);
      idle_c();
      c_cl = 1'b1; c_ca = 3'(i);
    end
    @(negedge clk);
    idle_c();
    c_we0 = 1'b1; c_wa0 = 3'd2; c_wd0 = 16'hBEEF;
    c_ra1 = 3'd0;
    #1;
    chk("sweep busy_vec claims", {24'b0, c_bv}, 32'h55);
    chk("sweep rbusy1 r0", {31'b0, c_rb1}, 32'h1);
    @(negedge clk);
    idle_c();
    #1;
    chk("sweep busy_vec after write", {24'b0, c_bv}, 32'h51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
